// File: rtl/keypad_emulator.sv
// Responder side of a 3x4 keypad column scan: returns row lines for one scripted key press
// with bounce-in, stable hold, bounce-out and release gap phases.
//
// state      | meaning
// S_IDLE     | waiting for a request, key released, req_ready high
// S_BOUNCE_IN| contact bounce on press, key_down starts at 1 and toggles
// S_HOLD     | key held steady for max(req_hold,1) cycles
// S_BOUNCE_OUT| contact bounce on release, key_down starts at 0 and toggles
// S_GAP      | key released, settling time before done
module keypad_emulator #(
    parameter int HOLD_W        = 24,
    parameter int BOUNCE_CYC    = 16,
    parameter int BOUNCE_PERIOD = 4,
    parameter int GAP_CYC       = 8
) (
    input  logic              fin,
    input  logic              rst_n,
    input  logic [2:0]        scan_key,
    output logic [3:0]        touch_key,
    input  logic              req_valid,
    input  logic [3:0]        req_key,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PH_MAX = (BOUNCE_CYC > GAP_CYC) ? BOUNCE_CYC : GAP_CYC;
    localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
    localparam int PER_W  = (BOUNCE_PERIOD > 2) ? $clog2(BOUNCE_PERIOD) : 1;

    localparam bit HAS_BOUNCE = (BOUNCE_CYC > 0);
    localparam bit HAS_GAP    = (GAP_CYC > 0);

    localparam logic [PH_W-1:0]  BOUNCE_LOAD = PH_W'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
    localparam logic [PH_W-1:0]  GAP_LOAD    = PH_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [PER_W-1:0] PER_LOAD    = PER_W'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT,
        S_GAP
    } state_t;

    state_t             state;
    logic               key_down;
    logic [3:0]         key_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [PH_W-1:0]    ph_cnt;
    logic [PER_W-1:0]   per_cnt;
    logic               done_q;
    logic               err_q;

    logic [2:0]         key_col;
    logic [3:0]         key_row;
    logic [HOLD_W-1:0]  hold_load;

    assign hold_load = (req_hold == '0) ? '0 : req_hold - HOLD_W'(1);

    always_ff @(posedge fin) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            key_down <= 1'b0;
            key_q    <= '0;
            hold_cnt <= '0;
            ph_cnt   <= '0;
            per_cnt  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    key_down <= 1'b0;
                    if (req_valid) begin
                        if (req_key > 4'd11) begin
                            err_q <= 1'b1;
                        end else begin
                            key_q    <= req_key;
                            hold_cnt <= hold_load;
                            key_down <= 1'b1;
                            per_cnt  <= PER_LOAD;
                            ph_cnt   <= BOUNCE_LOAD;
                            state    <= HAS_BOUNCE ? S_BOUNCE_IN : S_HOLD;
                        end
                    end
                end
                S_BOUNCE_IN: begin
                    if (ph_cnt == '0) begin
                        key_down <= 1'b1;
                        state    <= S_HOLD;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                        if (per_cnt == '0) begin
                            key_down <= ~key_down;
                            per_cnt  <= PER_LOAD;
                        end else begin
                            per_cnt <= per_cnt - PER_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        key_down <= 1'b0;
                        per_cnt  <= PER_LOAD;
                        if (HAS_BOUNCE) begin
                            ph_cnt <= BOUNCE_LOAD;
                            state  <= S_BOUNCE_OUT;
                        end else if (HAS_GAP) begin
                            ph_cnt <= GAP_LOAD;
                            state  <= S_GAP;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                S_BOUNCE_OUT: begin
                    if (ph_cnt == '0) begin
                        key_down <= 1'b0;
                        if (HAS_GAP) begin
                            ph_cnt <= GAP_LOAD;
                            state  <= S_GAP;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                        if (per_cnt == '0) begin
                            key_down <= ~key_down;
                            per_cnt  <= PER_LOAD;
                        end else begin
                            per_cnt <= per_cnt - PER_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    key_down <= 1'b0;
                    if (ph_cnt == '0) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end
                default: begin
                    key_down <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Keys 10 ('*') and 11 ('#') sit on the bottom row beside 0.
    always_comb begin
        key_col = 3'b000;
        key_row = 4'b0000;
        case (key_q)
            4'd1, 4'd4, 4'd7, 4'd10: key_col = 3'b100;
            4'd2, 4'd5, 4'd8, 4'd0:  key_col = 3'b010;
            4'd3, 4'd6, 4'd9, 4'd11: key_col = 3'b001;
            default:                 key_col = 3'b000;
        endcase
        case (key_q)
            4'd1, 4'd2, 4'd3:        key_row = 4'b1000;
            4'd4, 4'd5, 4'd6:        key_row = 4'b0100;
            4'd7, 4'd8, 4'd9:        key_row = 4'b0010;
            4'd10, 4'd0, 4'd11:      key_row = 4'b0001;
            default:                 key_row = 4'b0000;
        endcase
    end

    // Non-one-hot scan patterns never match a column code, so they read as no key.
    assign touch_key = (key_down && (scan_key == key_col)) ? key_row : 4'b0000;
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one instance without bounce (short gap), one with
// bounce phases, each driven through scripted presses with hand-computed expectations.
module tb_keypad_emulator;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [2:0]  scan_a, scan_b;
    logic [3:0]  touch_a, touch_b;
    logic        valid_a, valid_b;
    logic [3:0]  key_a, key_b;
    logic [23:0] hold_a, hold_b;
    logic        ready_a, ready_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

    int total = 0;
    int bad   = 0;
    int dcount;

    logic [2:0]  cols [3]     = '{3'b100, 3'b010, 3'b001};
    logic [2:0]  col_tab [12] = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010,
                                  3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b001};
    logic [3:0]  row_tab [12] = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100,
                                  4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    logic [27:0] exp_seq      = 28'b1100_1100_1111_0011_0011_0000_0000;
    logic [3:0]  exp_touch;

    always #5 clk = ~clk;

    keypad_emulator #(.HOLD_W(24), .BOUNCE_CYC(0), .BOUNCE_PERIOD(4), .GAP_CYC(2)) dut_a (
        .fin(clk), .rst_n(rst_n), .scan_key(scan_a), .touch_key(touch_a),
        .req_valid(valid_a), .req_key(key_a), .req_hold(hold_a),
        .req_ready(ready_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    keypad_emulator #(.HOLD_W(24), .BOUNCE_CYC(8), .BOUNCE_PERIOD(2), .GAP_CYC(8)) dut_b (
        .fin(clk), .rst_n(rst_n), .scan_key(scan_b), .touch_key(touch_b),
        .req_valid(valid_b), .req_key(key_b), .req_hold(hold_b),
        .req_ready(ready_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (done_a !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done_a}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        scan_a = 3'b010; scan_b = 3'b100;
        valid_a = 1'b0; valid_b = 1'b0;
        key_a = 4'd0; key_b = 4'd0;
        hold_a = '0; hold_b = '0;
        tick();
        tick();
        chk("rst_touch_a", touch_a, 4'b0000);
        chk("rst_ready_a", ready_a, 1'b1);
        chk("rst_busy_a",  busy_a,  1'b0);
        chk("rst_done_a",  done_a,  1'b0);
        chk("rst_err_a",   err_a,   1'b0);
        chk("rst_ready_b", ready_b, 1'b1);
        chk("rst_busy_b",  busy_b,  1'b0);
        rst_n = 1'b1;
        tick();

        // T1: key 5, hold 10, no bounce, gap 2
        scan_a = 3'b010; key_a = 4'd5; hold_a = 24'd10; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk("t1_hold", touch_a, 4'b0100);
            if (i == 1) begin
                chk("t1_busy",  busy_a,  1'b1);
                chk("t1_ready", ready_a, 1'b0);
                chk("t1_err",   err_a,   1'b0);
            end
            if (i == 5) begin
                scan_a = 3'b100; #1;
                chk("t1_wrong_col", touch_a, 4'b0000);
                scan_a = 3'b011; #1;
                chk("t1_scan_011", touch_a, 4'b0000);
                scan_a = 3'b010; #1;
            end
            tick();
        end
        for (int i = 11; i <= 12; i++) begin
            chk("t1_gap_touch", touch_a, 4'b0000);
            chk("t1_gap_done",  done_a,  1'b0);
            chk("t1_gap_busy",  busy_a,  1'b1);
            tick();
        end
        chk("t1_done",       done_a,  1'b1);
        chk("t1_done_ready", ready_a, 1'b1);
        chk("t1_done_touch", touch_a, 4'b0000);
        tick();
        chk("t1_done_pulse", done_a, 1'b0);

        // T2: every key against every column, hold 3
        for (int k = 0; k < 12; k++) begin
            key_a = k[3:0]; hold_a = 24'd3; valid_a = 1'b1;
            tick();
            valid_a = 1'b0;
            for (int c = 0; c < 3; c++) begin
                scan_a = cols[c]; #1;
                exp_touch = (col_tab[k] == cols[c]) ? row_tab[k] : 4'b0000;
                chk("t2_sweep", touch_a, exp_touch);
            end
            scan_a = 3'b011; #1;
            chk("t2_scan_011", touch_a, 4'b0000);
            wait_done_a("t2_done");
        end

        // T4: invalid key rejected
        scan_a = 3'b001; key_a = 4'd12; hold_a = 24'd5; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        chk("t4_err",   err_a,   1'b1);
        chk("t4_busy",  busy_a,  1'b0);
        chk("t4_ready", ready_a, 1'b1);
        chk("t4_touch", touch_a, 4'b0000);
        tick();
        chk("t4_err_pulse", err_a,   1'b0);
        chk("t4_touch2",    touch_a, 4'b0000);
        chk("t4_busy2",     busy_a,  1'b0);

        // T5: req_valid held through a press, hold 0 acts as 1
        scan_a = 3'b010; key_a = 4'd2; hold_a = 24'd0; valid_a = 1'b1;
        tick();
        chk("t5_c1_touch", touch_a, 4'b1000);
        chk("t5_c1_ready", ready_a, 1'b0);
        tick();
        chk("t5_c2_touch", touch_a, 4'b0000);
        chk("t5_c2_ready", ready_a, 1'b0);
        chk("t5_c2_busy",  busy_a,  1'b1);
        tick();
        chk("t5_c3_done",  done_a,  1'b0);
        tick();
        chk("t5_c4_done",  done_a,  1'b1);
        chk("t5_c4_ready", ready_a, 1'b1);
        tick();
        chk("t5_c5_touch", touch_a, 4'b1000);
        chk("t5_c5_busy",  busy_a,  1'b1);
        chk("t5_c5_done",  done_a,  1'b0);
        valid_a = 1'b0;
        wait_done_a("t5_done2");

        // T3: bounce profile on the second instance
        scan_b = 3'b100; key_b = 4'd1; hold_b = 24'd4; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        for (int i = 0; i < 28; i++) begin
            exp_touch = {exp_seq[27 - i], 3'b000};
            chk("t3_seq", touch_b, exp_touch);
            tick();
        end
        chk("t3_done",  done_b,  1'b1);
        chk("t3_ready", ready_b, 1'b1);
        chk("t3_touch", touch_b, 4'b0000);

        // T6: reset during hold aborts without done
        tick();
        scan_a = 3'b010; key_a = 4'd5; hold_a = 24'd10; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        tick();
        tick();
        chk("t6_pre_touch", touch_a, 4'b0100);
        rst_n = 1'b0;
        tick();
        chk("t6_touch", touch_a, 4'b0000);
        chk("t6_busy",  busy_a,  1'b0);
        chk("t6_ready", ready_a, 1'b1);
        chk("t6_done",  done_a,  1'b0);
        rst_n = 1'b1;
        dcount = 0;
        repeat (20) begin
            tick();
            if (done_a) dcount++;
        end
        chk("t6_no_done", dcount, 0);
        chk("t6_idle",    busy_a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
